rf_multiport: RTL and testbench
===============================

Name: rf_multiport

Overview:
Parametrised multi-ported integer register file. It succeeds the single-write, dual-read register file. It adds configurable read/write port counts, same-cycle write-to-read bypass, a hardwired zero register, synchronous clear on reset, and a per-register pending-write scoreboard. It sits between decode (read ports, scoreboard set) and writeback (write ports) of the NPC core.

Parameters:
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
DATA_WIDTH, 32, register data width
NUM_RD, 2, number of read ports (>=1)
NUM_WR, 2, number of write ports (>=1)
BYPASS, 1, 1 = read ports return same-cycle write data; 0 = return stored value
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and scoreboard sets

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
wen  input  NUM_WR  per-port write enable
waddr  input  NUM_WR*ADDR_WIDTH  write index; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
wdata  input  NUM_WR*DATA_WIDTH  write data; port i at bits [i*DATA_WIDTH +: DATA_WIDTH]
raddr  input  NUM_RD*ADDR_WIDTH  read index, packed as for waddr
rdata  output  NUM_RD*DATA_WIDTH  read data, combinational
sb_set  input  1  mark sb_addr as having a pending write
sb_addr  input  ADDR_WIDTH  scoreboard set index
rbusy  output  NUM_RD  per read port: pending bit of raddr, combinational
busy_vec  output  2**ADDR_WIDTH  full scoreboard state, registered

Behaviour:
- State: data array rf[0..2**ADDR_WIDTH-1] and scoreboard pend[0..2**ADDR_WIDTH-1].
- Reset, rst=1 at a rising edge:
  - every rf entry becomes 0; every pend bit becomes 0.
  - wen and sb_set are ignored that cycle.
  - After the edge, all rdata=0, rbusy=0, busy_vec=0.
  - Mid-operation reset discards all in-flight writes and pending marks.
- Write, rst=0:
  - For each port i with wen[i]=1, rf[waddr_i] <= wdata_i at the edge; visible to a plain read the next cycle.
  - Multiple ports with the same address in one cycle: the highest-numbered port wins.
  - Different addresses all commit in the same cycle.
  - ZERO_REG=1: writes to address 0 are dropped, and rdata for address 0 is always 0.
- Read: combinational, zero-latency.
  - BYPASS=1: if any wen[i]=1 with waddr_i==raddr_j (and not a dropped zero-reg write), rdata_j = wdata of the highest-numbered matching port. Otherwise rdata_j = rf[raddr_j].
  - BYPASS=0: rdata_j = rf[raddr_j] always.
  - Bypass is suppressed while rst=1.
- Scoreboard, rst=0, evaluated per address at each edge:
  - set = sb_set && sb_addr==a && !(ZERO_REG && a==0)
  - clr = any wen[i] with waddr_i==a
  - set wins over clr: a new producer was issued in the same cycle the old one retired.
  - Otherwise clr -> pend[a]<=0, set -> pend[a]<=1, neither -> hold.
  - Writing an address whose pend bit is 0 is legal and leaves it 0.
- rbusy_j = pend[raddr_j] (registered state, no bypass). A write in cycle N clears rbusy from cycle N+1.
- ZERO_REG=1: pend[0] is constantly 0.
- Widths: no arithmetic; addresses are full range and wrap is not applicable. Out-of-range parameters (NUM_RD or NUM_WR = 0) are unsupported.

Test Plan:
1. Reset: preload rf[5]=0xDEADBEEF and pend[5]=1, assert rst for one edge while wen[0]=1 to addr 5 -> next cycle rdata(raddr=5)=0, busy_vec=0; the write is ignored.
2. Basic write/read: port0 writes 0x11 to r3 and port1 writes 0x22 to r4 in one cycle -> next cycle read r3=0x11, r4=0x22 on both read ports.
3. Conflict and bypass: port0 writes 0xAAAA to r7 and port1 writes 0xBBBB to r7; raddr0=7 in the same cycle -> BYPASS=1: rdata0=0xBBBB immediately; BYPASS=0: rdata0=old value, then 0xBBBB next cycle. rf[7]=0xBBBB afterwards in both cases.
4. Zero register: write 0x1234 to r0 with bypass active, plus sb_set on r0 -> rdata=0 in the same and next cycle, busy_vec[0]=0. With ZERO_REG=0, r0 reads 0x1234 and busy_vec[0]=1.
5. Scoreboard: sb_set r9 -> rbusy=1 next cycle; hold 3 cycles; write r9 -> rbusy=0 the cycle after. Then sb_set r9 and write r9 in the same cycle -> pend[9]=1 stays.
6. Reset mid-operation: pend set on r1, r2, r3 plus writes in flight; assert rst -> all pend and rf cleared next cycle. Then normal writes resume on the first cycle after rst drops.

Source files
------------

// File: rtl/rf_multiport.sv
// rf_multiport -- multi-ported integer register file with write-to-read
// bypass, an optional hardwired zero register and a per-register
// pending-write scoreboard.
//
// Ports:
//   clk       clock; all state updates on the rising edge
//   rst       synchronous active-high reset; clears data and scoreboard
//   wen       per-write-port enable           [NUM_WR]
//   waddr     packed write indices            [NUM_WR*ADDR_WIDTH]
//   wdata     packed write data               [NUM_WR*DATA_WIDTH]
//   raddr     packed read indices             [NUM_RD*ADDR_WIDTH]
//   rdata     packed read data, combinational [NUM_RD*DATA_WIDTH]
//   sb_set    mark sb_addr as having a pending write
//   sb_addr   scoreboard set index            [ADDR_WIDTH]
//   rbusy     pending bit of each read index, combinational [NUM_RD]
//   busy_vec  full scoreboard state, registered [2**ADDR_WIDTH]
module rf_multiport #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_WR-1:0]              wen,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]   waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0]   wdata,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rdata,
  input  logic                           sb_set,
  input  logic [ADDR_WIDTH-1:0]          sb_addr,
  output logic [NUM_RD-1:0]              rbusy,
  output logic [(1<<ADDR_WIDTH)-1:0]     busy_vec
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf [DEPTH];
  logic [DEPTH-1:0]      pend;
  logic [DEPTH-1:0]      pend_next;

  logic [ADDR_WIDTH-1:0] waddr_a [NUM_WR];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_WR];
  logic [ADDR_WIDTH-1:0] raddr_a [NUM_RD];
  // Write enables with dropped zero-register writes already removed.
  logic [NUM_WR-1:0]     wen_eff;

  for (genvar i = 0; i < NUM_WR; i++) begin : g_wr_unpack
    assign waddr_a[i] = waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[i] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign wen_eff[i] = wen[i] && !((ZERO_REG != 0) && (waddr_a[i] == '0));
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd_unpack
    assign raddr_a[j] = raddr[j*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Scoreboard next state. A set in the same cycle as a retiring write
  // means a new producer was issued, so set has priority over clear.
  // Clear uses the raw enables; for the hardwired zero register the bit
  // is forced low anyway.
  always_comb begin
    logic set_a;
    logic clr_a;
    pend_next = pend;
    for (int a = 0; a < DEPTH; a++) begin
      set_a = sb_set && (sb_addr == ADDR_WIDTH'(a))
              && !((ZERO_REG != 0) && (a == 0));
      clr_a = 1'b0;
      for (int i = 0; i < NUM_WR; i++) begin
        if (wen[i] && (waddr_a[i] == ADDR_WIDTH'(a))) clr_a = 1'b1;
      end
      if (set_a)      pend_next[a] = 1'b1;
      else if (clr_a) pend_next[a] = 1'b0;
    end
    if (ZERO_REG != 0) pend_next[0] = 1'b0;
  end

  // State update. Ports are visited in ascending order, so the last
  // non-blocking assignment (highest-numbered port) wins on a conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf   <= '{default: '0};
      pend <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wen_eff[i]) rf[waddr_a[i]] <= wdata_a[i];
      end
      pend <= pend_next;
    end
  end

  // Read ports: stored value, overridden by the highest-numbered matching
  // same-cycle write when bypass is enabled and reset is not asserted.
  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [DATA_WIDTH-1:0] rd_val;

    always_comb begin
      rd_val = rf[raddr_a[j]];
      if ((BYPASS != 0) && !rst) begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (wen_eff[i] && (waddr_a[i] == raddr_a[j])) rd_val = wdata_a[i];
        end
      end
      if ((ZERO_REG != 0) && (raddr_a[j] == '0)) rd_val = '0;
    end

    assign rdata[j*DATA_WIDTH +: DATA_WIDTH] = rd_val;
    assign rbusy[j] = pend[raddr_a[j]];
  end

  assign busy_vec = pend;

endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport -- directed bench for rf_multiport. Two instances share
// the stimulus: dut_a uses the defaults (bypass, zero register) and dut_b
// has BYPASS=0, ZERO_REG=0. Expected values are queued as stimulus is
// applied and popped against the outputs once they have settled.
module tb_rf_multiport;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wen;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [9:0]  raddr;
  logic        sb_set;
  logic [4:0]  sb_addr;

  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  rbusy_a, rbusy_b;
  logic [31:0] busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  // Output selectors for the scoreboard.
  localparam int RD0A = 0, RD1A = 1, RBA = 2, BVA = 3;
  localparam int RD0B = 4, RD1B = 5, RBB = 6, BVB = 7;

  string       tag_q [$];
  int          sel_q [$];
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  rf_multiport dut_a (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_a), .sb_set(sb_set), .sb_addr(sb_addr),
    .rbusy(rbusy_a), .busy_vec(busy_a)
  );

  rf_multiport #(.BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_b), .sb_set(sb_set), .sb_addr(sb_addr),
    .rbusy(rbusy_b), .busy_vec(busy_b)
  );

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      RD0A:    return {32'h0, rdata_a[31:0]};
      RD1A:    return {32'h0, rdata_a[63:32]};
      RBA:     return {62'h0, rbusy_a};
      BVA:     return {32'h0, busy_a};
      RD0B:    return {32'h0, rdata_b[31:0]};
      RD1B:    return {32'h0, rdata_b[63:32]};
      RBB:     return {62'h0, rbusy_b};
      default: return {32'h0, busy_b};
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [63:0] v);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    exp_q.push_back(v);
  endtask

  // Let combinational outputs settle, then compare everything queued.
  task automatic drain();
    string       t;
    int          s;
    logic [63:0] e;
    logic [63:0] o;
    #1;
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front();
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      o = observe(s);
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", t, o, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen    = 2'b00;
    sb_set = 1'b0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wen[p] = 1'b1;
    waddr[p*5 +: 5]   = a;
    wdata[p*32 +: 32] = d;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    raddr = {a1, a0};
  endtask

  task automatic mark(input logic [4:0] a);
    sb_set  = 1'b1;
    sb_addr = a;
  endtask

  initial begin
    rst = 1'b1; wen = '0; waddr = '0; wdata = '0; raddr = '0;
    sb_set = 1'b0; sb_addr = '0;
    step(); step();
    rst = 1'b0;

    // Reset state.
    rd(5'd5, 5'd9);
    expect_val("reset_rd0", RD0A, 64'h0);
    expect_val("reset_bv", BVA, 64'h0);
    expect_val("reset_rbusy", RBA, 64'h0);
    expect_val("reset_bv_b", BVB, 64'h0);
    drain();

    // 1. Preload r5 and pend[5], then reset with a write in flight.
    wr(0, 5'd5, 32'hDEADBEEF); mark(5'd5);
    step(); idle();
    expect_val("pre_rd5", RD0A, 64'hDEADBEEF);
    expect_val("pre_bv5", BVA, 64'h20);
    drain();
    rst = 1'b1; wr(0, 5'd5, 32'h55); mark(5'd6);
    expect_val("rst_nobypass", RD0A, 64'hDEADBEEF);
    drain();
    step(); rst = 1'b0; idle();
    expect_val("rst_rd5", RD0A, 64'h0);
    expect_val("rst_bv", BVA, 64'h0);
    expect_val("rst_rbusy", RBA, 64'h0);
    expect_val("rst_rd5_b", RD0B, 64'h0);
    expect_val("rst_bv_b", BVB, 64'h0);
    drain();

    // 2. Two ports, two addresses.
    wr(0, 5'd3, 32'h11); wr(1, 5'd4, 32'h22); rd(5'd3, 5'd4);
    expect_val("byp_r3", RD0A, 64'h11);
    expect_val("byp_r4", RD1A, 64'h22);
    expect_val("nobyp_r3", RD0B, 64'h0);
    expect_val("nobyp_r4", RD1B, 64'h0);
    drain();
    step(); idle();
    expect_val("wr_r3", RD0A, 64'h11);
    expect_val("wr_r4", RD1A, 64'h22);
    expect_val("wr_r3_b", RD0B, 64'h11);
    expect_val("wr_r4_b", RD1B, 64'h22);
    drain();
    rd(5'd4, 5'd3);
    expect_val("swap_rd0", RD0A, 64'h22);
    expect_val("swap_rd1", RD1A, 64'h11);
    drain();

    // 3. Same-address conflict with bypass.
    wr(0, 5'd7, 32'h77); step(); idle();
    wr(0, 5'd7, 32'hAAAA); wr(1, 5'd7, 32'hBBBB); rd(5'd7, 5'd3);
    expect_val("conf_byp", RD0A, 64'hBBBB);
    expect_val("conf_old_b", RD0B, 64'h77);
    drain();
    step(); idle();
    expect_val("conf_rf7", RD0A, 64'hBBBB);
    expect_val("conf_rf7_b", RD0B, 64'hBBBB);
    drain();

    // 4. Zero register write with scoreboard set.
    wr(0, 5'd0, 32'h1234); mark(5'd0); rd(5'd0, 5'd7);
    expect_val("zero_same", RD0A, 64'h0);
    expect_val("zero_same_b", RD0B, 64'h0);
    drain();
    step(); idle();
    expect_val("zero_next", RD0A, 64'h0);
    expect_val("zero_bv", BVA, 64'h0);
    expect_val("nozero_rd", RD0B, 64'h1234);
    expect_val("nozero_bv", BVB, 64'h1);
    drain();

    // 5. Scoreboard lifecycle on r9.
    rd(5'd3, 5'd9); mark(5'd9);
    expect_val("sb_same", RBA, 64'h0);
    drain();
    step(); idle();
    for (int k = 0; k < 3; k++) begin
      expect_val("sb_hold_rb", RBA, 64'h2);
      expect_val("sb_hold_bv", BVA, 64'h200);
      drain();
      step();
    end
    wr(1, 5'd9, 32'h99);
    expect_val("sb_wr_rb", RBA, 64'h2);
    expect_val("sb_wr_byp", RD1A, 64'h99);
    drain();
    step(); idle();
    expect_val("sb_clr_rb", RBA, 64'h0);
    expect_val("sb_clr_bv", BVA, 64'h0);
    drain();
    mark(5'd9); wr(0, 5'd9, 32'h9A);
    step(); idle();
    expect_val("sb_setwin_bv", BVA, 64'h200);
    expect_val("sb_setwin_rb", RBA, 64'h2);
    drain();

    // 6. Reset mid-operation.
    mark(5'd1); step();
    mark(5'd2); step();
    mark(5'd3); wr(0, 5'd10, 32'hA0); wr(1, 5'd11, 32'hB0);
    step(); idle();
    expect_val("mid_bv", BVA, 64'h20E);
    drain();
    rst = 1'b1; wr(0, 5'd12, 32'hC0); mark(5'd4);
    step(); rst = 1'b0; idle();
    rd(5'd10, 5'd11);
    expect_val("mid_bv_clr", BVA, 64'h0);
    expect_val("mid_r10", RD0A, 64'h0);
    expect_val("mid_r11", RD1A, 64'h0);
    expect_val("mid_bv_clr_b", BVB, 64'h0);
    drain();
    rd(5'd3, 5'd7);
    expect_val("mid_r3", RD0A, 64'h0);
    expect_val("mid_r7_b", RD1B, 64'h0);
    drain();
    wr(0, 5'd12, 32'hC1); mark(5'd5); rd(5'd12, 5'd5);
    expect_val("resume_byp", RD0A, 64'hC1);
    drain();
    step(); idle();
    expect_val("resume_r12", RD0A, 64'hC1);
    expect_val("resume_r12_b", RD0B, 64'hC1);
    expect_val("resume_bv", BVA, 64'h20);
    expect_val("resume_rb", RBA, 64'h2);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
